// File: rtl/axis_packet_player.sv
// Replays a preloaded table of AXI4-Stream beats as a bounded or endless
// sequence of passes, with an optional idle gap after every packet.
module axis_packet_player #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  parameter  int GAP_W  = 8,
  parameter  int LOOP_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int KW     = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KW-1:0]     wr_keep,
  input  logic              wr_last,
  input  logic              start,
  input  logic [AW:0]       cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [LOOP_W-1:0] cfg_loops,
  input  logic              abort,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KW-1:0]     m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_cnt
);

  localparam int          EW        = DATA_W + KW + 1;
  localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_idx;
  logic [AW:0]       r_len;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [LOOP_W-1:0] r_loops;
  logic [LOOP_W-1:0] r_pass;
  logic              r_abort;
  logic              r_done;
  logic [15:0]       r_pkt_cnt;

  logic [EW-1:0]     w_entry;
  logic              w_start_ok;
  logic              w_at_end;
  logic              w_hs;
  logic              w_tlast;
  logic              w_last_hs;
  logic [LOOP_W-1:0] w_pass_inc;
  logic              w_final;
  logic              w_abort_pend;

  assign w_entry      = r_mem[r_idx];
  assign w_start_ok   = start && (cfg_len != '0) && (cfg_len <= DEPTH_LEN);
  assign w_at_end     = ({1'b0, r_idx} == (r_len - (AW + 1)'(1)));
  assign w_hs         = (r_state == ST_PLAY) && m_axis_tready;
  // Forcing tlast on the final index keeps every pass packet-aligned.
  assign w_tlast      = w_entry[EW-1] || w_at_end;
  assign w_last_hs    = w_hs && w_tlast;
  assign w_pass_inc   = r_pass + LOOP_W'(1);
  assign w_final      = w_hs && w_at_end && (r_loops != '0) && (w_pass_inc == r_loops);
  assign w_abort_pend = r_abort || abort;

  // NOTE: the beat table is storage, not state; leaving it out of reset lets it map to RAM.
  always_ff @(posedge aclk) begin
    if (wr_en && (r_state == ST_IDLE)) begin
      r_mem[wr_addr] <= {wr_last, wr_keep, wr_data};
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start_ok) w_next = ST_PLAY;
      ST_PLAY: begin
        if (w_last_hs) begin
          if (w_final || w_abort_pend) w_next = ST_IDLE;
          else if (r_gap != '0)        w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_abort_pend)                w_next = ST_IDLE;
        else if (r_gap_cnt == GAP_W'(1)) w_next = ST_PLAY;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != ST_IDLE);
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    if (r_state == ST_PLAY) begin
      m_axis_tvalid = 1'b1;
      m_axis_tdata  = w_entry[DATA_W-1:0];
      m_axis_tkeep  = w_entry[DATA_W +: KW];
      m_axis_tlast  = w_tlast;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx     <= '0;
      r_len     <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_loops   <= '0;
      r_pass    <= '0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_len     <= cfg_len;
            r_gap     <= cfg_gap;
            r_loops   <= cfg_loops;
            r_idx     <= '0;
            r_pass    <= '0;
            r_pkt_cnt <= '0;
          end
        end
        ST_PLAY: begin
          if (w_hs) begin
            r_idx     <= w_at_end ? '0 : r_idx + AW'(1);
            r_gap_cnt <= r_gap;
            if (w_at_end) r_pass <= w_pass_inc;
          end
          if (w_last_hs && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
        ST_GAP:  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        default: ;
      endcase
      // A single exit edge yields a single done, even when abort and final pass coincide.
      if ((r_state != ST_IDLE) && (w_next == ST_IDLE)) begin
        r_done  <= 1'b1;
        r_abort <= 1'b0;
      end else if (abort && (r_state != ST_IDLE)) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign done    = r_done;
  assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_axis_packet_player.sv
// Scoreboard bench for axis_packet_player: expected beats are queued at start,
// a negedge monitor pops and compares every handshake and measures gaps.
module tb_axis_packet_player;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int GAP_W  = 8;
  localparam int LOOP_W = 8;
  localparam int AW     = 6;
  localparam int KW     = 4;

  typedef logic [DATA_W+KW:0] beat_t;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [KW-1:0]     wr_keep = '0;
  logic              wr_last = 1'b0;
  logic              start = 1'b0;
  logic [AW:0]       cfg_len = '0;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic [LOOP_W-1:0] cfg_loops = '0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              busy;
  logic              done;
  logic [15:0]       pkt_cnt;

  axis_packet_player #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_W(GAP_W), .LOOP_W(LOOP_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_keep(wr_keep), .wr_last(wr_last),
    .start(start), .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_loops(cfg_loops), .abort(abort),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
  );

  always #5 aclk = ~aclk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  beat_t model_mem [DEPTH];
  beat_t exp_q [$];

  int    n_hs = 0, n_tlast = 0, n_done = 0;
  int    last_hs_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic  last_hs_last = 1'b0;
  int    gaps [$];
  int    gap_run = 0;
  bit    after_last = 1'b0;
  bit    prev_v = 1'b0, prev_r = 1'b0;
  beat_t prev_beat = '0;

  bit    rand_mode = 1'b0;
  logic  tready_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  always begin
    @(posedge aclk);
    #2;
    m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_hold;
  end

  // Monitor: scoreboard pops, hold-while-stalled, gap lengths, done pulses.
  always @(negedge aclk) begin
    beat_t cur;
    cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (!aresetn) begin
      prev_v     = 1'b0;
      after_last = 1'b0;
    end else begin
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (after_last && m_axis_tvalid) begin
        gaps.push_back(gap_run);
        after_last = 1'b0;
      end
      if (prev_v && !prev_r) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_beat", cur, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_hs++;
        last_hs_cyc  = cyc;
        last_hs_last = m_axis_tlast;
        if (exp_q.size() == 0) check("extra_beat", n_hs, 0);
        else check("beat", cur, exp_q.pop_front());
        if (m_axis_tlast) begin
          n_tlast++;
          after_last = 1'b1;
          gap_run    = 0;
        end
      end else if (after_last && !m_axis_tvalid) begin
        if (busy) gap_run++;
        else after_last = 1'b0;
      end
      prev_v    = m_axis_tvalid;
      prev_r    = m_axis_tready;
      prev_beat = cur;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_beat(input int addr, input logic [DATA_W-1:0] d, input logic [KW-1:0] k,
                            input logic l, input bit upd);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = d;
    wr_keep = k;
    wr_last = l;
    if (upd) model_mem[addr] = {l, k, d};
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load19();
    for (int i = 0; i < 19; i++) write_beat(i, $urandom, 4'($urandom_range(1, 15)), i == 18, 1'b1);
  endtask

  task automatic load12();
    for (int i = 0; i < 12; i++)
      write_beat(i, $urandom, 4'($urandom_range(1, 15)), (i == 5) || (i == 11), 1'b1);
  endtask

  task automatic start_play(input int len, input int gap, input int loops, input int passes);
    beat_t e;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < len; i++) begin
        e = model_mem[i];
        if (i == len - 1) e[DATA_W+KW] = 1'b1;
        exp_q.push_back(e);
      end
    end
    cfg_len   = (AW + 1)'(len);
    cfg_gap   = GAP_W'(gap);
    cfg_loops = LOOP_W'(loops);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    check("valid_rise", m_axis_tvalid, 1'b1);
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k = 0;
    while (n_done == base && k < budget) begin
      tick();
      k++;
    end
    check(tag, n_done != base, 1'b1);
  endtask

  task automatic wait_hs(input int target, input int budget, input string tag);
    int k = 0;
    while (n_hs < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, n_hs >= target, 1'b1);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_hs, b_tl, b_gaps;

    #3;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_tkeep", m_axis_tkeep, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 16'h0);
    #20 aresetn = 1'b1;
    tick();

    // Single 19-beat packet, back-to-back.
    load19();
    tready_hold = 1'b1;
    tick();
    b_done = n_done; b_hs = n_hs; b_tl = n_tlast;
    start_play(19, 0, 1, 1);
    wait_done(b_done, 100, "t1_done_seen");
    repeat (4) tick();
    check("t1_beats", n_hs - b_hs, 19);
    check("t1_tlasts", n_tlast - b_tl, 1);
    check("t1_contiguous", last_hs_cyc - start_cyc, 18);
    check("t1_done_lat", done_cyc - last_hs_cyc, 1);
    check("t1_done_once", n_done - b_done, 1);
    check("t1_pkt_cnt", pkt_cnt, 16'd1);
    check("t1_q_empty", exp_q.size(), 0);

    // Two passes of two packets with 3-cycle gaps; abort lands in the final packet.
    load12();
    tick();
    b_done = n_done; b_hs = n_hs; b_tl = n_tlast; b_gaps = gaps.size();
    start_play(12, 3, 2, 2);
    wait_hs(b_hs + 19, 200, "t2_reach_last_pkt");
    pulse_abort();
    wait_done(b_done, 200, "t2_done_seen");
    repeat (4) tick();
    check("t2_beats", n_hs - b_hs, 24);
    check("t2_tlasts", n_tlast - b_tl, 4);
    check("t2_pkt_cnt", pkt_cnt, 16'd4);
    check("t2_gap_count", gaps.size() - b_gaps, 3);
    for (int i = b_gaps; i < gaps.size(); i++) check("t2_gap_len", gaps[i], 3);
    check("t2_done_lat", done_cyc - last_hs_cyc, 1);
    check("t2_done_once", n_done - b_done, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // Random backpressure over two 19-beat passes.
    load19();
    rand_mode = 1'b1;
    tick();
    b_done = n_done; b_hs = n_hs;
    start_play(19, 1, 2, 2);
    wait_done(b_done, 800, "t3_done_seen");
    rand_mode = 1'b0;
    repeat (4) tick();
    check("t3_beats", n_hs - b_hs, 38);
    check("t3_pkt_cnt", pkt_cnt, 16'd2);
    check("t3_done_once", n_done - b_done, 1);
    check("t3_q_empty", exp_q.size(), 0);

    // Endless play; abort mid-packet lets that packet finish.
    load12();
    tick();
    b_done = n_done; b_hs = n_hs; b_tl = n_tlast;
    start_play(12, 2, 0, 10);
    repeat (28) tick();
    pulse_abort();
    wait_done(b_done, 200, "t4_done_seen");
    repeat (4) tick();
    check("t4_ends_on_tlast", last_hs_last, 1'b1);
    check("t4_beats", n_hs - b_hs, 24);
    check("t4_pkt_cnt", pkt_cnt, 16'd4);
    check("t4_pkt_vs_tlast", pkt_cnt, 16'(n_tlast - b_tl));
    check("t4_done_once", n_done - b_done, 1);
    exp_q.delete();
    b_done = n_done;
    pulse_abort();
    repeat (4) tick();
    check("t4_idle_abort_busy", busy, 1'b0);
    check("t4_idle_abort_done", n_done - b_done, 0);
    b_hs = n_hs;
    start_play(12, 0, 1, 1);
    wait_done(b_done, 100, "t4b_done_seen");
    repeat (2) tick();
    check("t4b_full_pass", n_hs - b_hs, 12);
    check("t4b_pkt_cnt", pkt_cnt, 16'd2);

    // Writes and start while busy are ignored; bad lengths ignored when idle.
    tready_hold = 1'b0;
    tick();
    b_done = n_done; b_hs = n_hs;
    start_play(12, 0, 1, 1);
    repeat (3) tick();
    write_beat(5, ~model_mem[5][DATA_W-1:0], 4'hF, 1'b0, 1'b0);
    tready_hold = 1'b1;
    wait_hs(b_hs + 4, 50, "t5_partial");
    tready_hold = 1'b0;
    repeat (2) tick();
    cfg_len = 7'd3; cfg_loops = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    tready_hold = 1'b1;
    wait_done(b_done, 100, "t5_done_seen");
    repeat (2) tick();
    check("t5_beats", n_hs - b_hs, 12);
    check("t5_pkt_cnt", pkt_cnt, 16'd2);
    check("t5_done_once", n_done - b_done, 1);
    check("t5_q_empty", exp_q.size(), 0);
    cfg_len = 7'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_len0_valid", m_axis_tvalid, 1'b0);
    check("t5_len0_busy", busy, 1'b0);
    cfg_len = 7'd65; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("t5_len65_valid", m_axis_tvalid, 1'b0);
    check("t5_len65_busy", busy, 1'b0);

    // Asynchronous reset while stalled mid-beat, then a fresh replay.
    tready_hold = 1'b0;
    tick();
    start_play(12, 0, 1, 1);
    repeat (3) tick();
    #3 aresetn = 1'b0;
    #1;
    check("t6_rst_valid", m_axis_tvalid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_pkt_cnt", pkt_cnt, 16'h0);
    exp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    tready_hold = 1'b1;
    repeat (3) tick();
    check("t6_idle_valid", m_axis_tvalid, 1'b0);
    check("t6_idle_busy", busy, 1'b0);
    b_done = n_done; b_hs = n_hs;
    start_play(12, 0, 1, 1);
    wait_done(b_done, 100, "t6_done_seen");
    repeat (2) tick();
    check("t6_beats", n_hs - b_hs, 12);
    check("t6_pkt_cnt", pkt_cnt, 16'd2);
    check("t6_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
